ram_address_generator: RTL and testbench
========================================

RAM_ADDRESS_GENERATOR -- requirements
Module: ram_address_generator

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 14: width of ram_addr, start_addr and end_addr.
REQ-002 Parameter MAX_RAM_ADDRESS, default 16384: address space size; SHALL satisfy 2 <= MAX_RAM_ADDRESS <= 2**ADDRESS_WIDTH.
REQ-003 Parameter BURST_LEN, default 8: addresses per burst in burst mode; SHALL be >= 1.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  advance permission; address consumed on an edge where addr_valid=1.
REQ-008 start  input  1  single-cycle request to latch configuration and begin a sequence.
REQ-009 abort  input  1  terminate current sequence.
REQ-010 start_addr  input  ADDRESS_WIDTH  first address of the sequence.
REQ-011 end_addr  input  ADDRESS_WIDTH  last address of the sequence.
REQ-012 wrap_mode  input  1  1: return to start_addr after end_addr; 0: stop after end_addr.
REQ-013 burst_mode  input  1  1: pause after every BURST_LEN consumed addresses.
REQ-014 burst_req  input  1  resume from burst pause.
REQ-015 ram_addr  output  ADDRESS_WIDTH  current address, registered.
REQ-016 addr_valid  output  1  ram_addr is valid for consumption this cycle.
REQ-017 burst_done  output  1  one-cycle pulse on entering burst pause.
REQ-018 wrap  output  1  one-cycle pulse in the first cycle ram_addr returns to start_addr.
REQ-019 done  output  1  level, high while in DONE.
REQ-020 busy  output  1  high in RUN or WAIT.

Function
REQ-021 FSM states SHALL be IDLE, RUN, WAIT, and DONE.
REQ-022 start in IDLE or DONE SHALL latch start_addr, end_addr, wrap_mode, and burst_mode, enter RUN, set ram_addr=start_addr, and clear the burst counter; latency SHALL be 1 edge.
REQ-023 start with start_addr or end_addr >= MAX_RAM_ADDRESS SHALL be ignored, with state unchanged.
REQ-024 start in RUN or WAIT SHALL be ignored.
REQ-025 addr_valid SHALL equal (state==RUN) & enable, combinationally; all other outputs SHALL be registered.
REQ-026 Consumption edge (addr_valid=1) with ram_addr != end_addr SHALL set ram_addr to (ram_addr+1) mod MAX_RAM_ADDRESS.
REQ-027 Sequences with end_addr < start_addr SHALL wrap through MAX_RAM_ADDRESS-1 to 0.
REQ-028 enable=0 in RUN SHALL hold ram_addr and all counters.
REQ-029 Consumption at ram_addr==end_addr, wrap_mode=0: enter DONE; ram_addr holds end_addr; done=1.
REQ-030 Consumption at ram_addr==end_addr, wrap_mode=1: ram_addr=start_addr; wrap=1 for one cycle; remain in RUN.
REQ-031 burst_mode=1: the burst counter SHALL count consumptions; on the BURST_LEN-th consumption, clear the counter, enter WAIT, and pulse burst_done.
REQ-032 ram_addr SHALL hold in WAIT.
REQ-033 burst_req in WAIT SHALL enter RUN on the next edge; burst_req in any other state SHALL be ignored.
REQ-034 Burst boundary coinciding with end_addr, wrap_mode=0: DONE SHALL win, and burst_done SHALL not pulse.
REQ-035 Burst boundary coinciding with end_addr, wrap_mode=1: wrap and burst_done SHALL both pulse, enter WAIT, and ram_addr=start_addr.
REQ-036 The burst counter SHALL not clear on wrap.
REQ-037 start_addr==end_addr SHALL give a one-address sequence; with wrap_mode=1, wrap SHALL pulse after each consumption.
REQ-038 abort in any non-IDLE state SHALL enter IDLE next edge; ram_addr retained; done/busy/pulses cleared.
REQ-039 abort SHALL take priority over start, burst_req and enable.
REQ-040 DONE SHALL persist until start or abort.

Reset
REQ-041 reset SHALL have highest priority over all inputs.
REQ-042 On the reset edge: state=IDLE; ram_addr=0; addr_valid, burst_done, wrap, done, and busy=0; burst counter=0; latched config=0.
REQ-043 Reset mid-RUN or mid-WAIT SHALL discard the sequence, with no pulses in the following cycle.

Verification (ADDRESS_WIDTH=4, MAX_RAM_ADDRESS=12, BURST_LEN=4)
REQ-044 Linear stop: start 2..5, wrap=0, burst=0, enable=1 -> ram_addr 2,3,4,5 valid; then done=1, ram_addr=5, valid=0.
REQ-045 Wrap: start 3..5, wrap=1 -> 3,4,5,3,4,5,...; wrap pulses in each cycle ram_addr=3 after the first pass; busy stays 1.
REQ-046 Modulo: start 10..1, wrap=0 -> 10,11,0,1; then done; start_addr=12 at start -> ignored, state stays IDLE.
REQ-047 Burst: start 0..11, burst=1 -> 0..3, burst_done pulse, ram_addr=4 held while burst_req=0 for 5 cycles; burst_req -> 4..7; at end 8..11, done and no burst_done.
REQ-048 Stall/abort: enable=0 for 3 cycles at ram_addr=6 -> ram_addr held at 6, valid=0; abort together with start -> IDLE, ram_addr=6, busy=0.
REQ-049 Reset mid-WAIT -> next cycle all outputs 0, IDLE; a subsequent burst_req is ignored.

Source files
------------

// File: rtl/ram_address_generator.sv
`default_nettype none
// ============================================================================
// Module   : ram_address_generator
// Brief    : Sequential RAM address generator with wrap and burst pacing.
// Revision : 1.0 - initial release
// ============================================================================
module ram_address_generator #(
  parameter int ADDRESS_WIDTH   = 14,
  parameter int MAX_RAM_ADDRESS = 16384,
  parameter int BURST_LEN       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH-1:0] end_addr,
  input  logic                     wrap_mode,
  input  logic                     burst_mode,
  input  logic                     burst_req,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     addr_valid,
  output logic                     burst_done,
  output logic                     wrap,
  output logic                     done,
  output logic                     busy
);

  localparam int                     c_cnt_w     = $clog2(BURST_LEN + 1);
  localparam logic [1:0]             c_idle      = 2'd0;
  localparam logic [1:0]             c_run       = 2'd1;
  localparam logic [1:0]             c_wait      = 2'd2;
  localparam logic [1:0]             c_done      = 2'd3;
  localparam logic [ADDRESS_WIDTH-1:0] c_last_addr = ADDRESS_WIDTH'(MAX_RAM_ADDRESS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] c_addr_one  = ADDRESS_WIDTH'(1);
  localparam logic [c_cnt_w-1:0]     c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]     c_cnt_last  = c_cnt_w'(BURST_LEN - 1);

  logic [1:0]               r_state, w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ADDRESS_WIDTH-1:0] r_start, w_start_nxt;
  logic [ADDRESS_WIDTH-1:0] r_end, w_end_nxt;
  logic                     r_wrap_mode, w_wrap_mode_nxt;
  logic                     r_burst_mode, w_burst_mode_nxt;
  logic [c_cnt_w-1:0]       r_cnt, w_cnt_nxt;
  logic                     r_burst_done, w_burst_done_nxt;
  logic                     r_wrap, w_wrap_nxt;
  logic                     r_done, r_busy;

  logic                     w_cfg_ok;
  logic                     w_at_end;
  logic                     w_burst_last;
  logic [ADDRESS_WIDTH-1:0] w_addr_inc;

  assign w_cfg_ok     = (32'(start_addr) < MAX_RAM_ADDRESS) && (32'(end_addr) < MAX_RAM_ADDRESS);
  assign w_at_end     = (r_addr == r_end);
  assign w_burst_last = (r_cnt == c_cnt_last);
  // Modulo increment: the address space need not be a power of two.
  assign w_addr_inc   = (r_addr == c_last_addr) ? '0 : r_addr + c_addr_one;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_idle;
      r_addr       <= '0;
      r_start      <= '0;
      r_end        <= '0;
      r_wrap_mode  <= 1'b0;
      r_burst_mode <= 1'b0;
      r_cnt        <= '0;
      r_burst_done <= 1'b0;
      r_wrap       <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_start      <= w_start_nxt;
      r_end        <= w_end_nxt;
      r_wrap_mode  <= w_wrap_mode_nxt;
      r_burst_mode <= w_burst_mode_nxt;
      r_cnt        <= w_cnt_nxt;
      r_burst_done <= w_burst_done_nxt;
      r_wrap       <= w_wrap_nxt;
      r_done       <= (w_state_nxt == c_done);
      r_busy       <= (w_state_nxt == c_run) || (w_state_nxt == c_wait);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_start_nxt      = r_start;
    w_end_nxt        = r_end;
    w_wrap_mode_nxt  = r_wrap_mode;
    w_burst_mode_nxt = r_burst_mode;
    w_cnt_nxt        = r_cnt;
    w_burst_done_nxt = 1'b0;
    w_wrap_nxt       = 1'b0;
    if (abort) begin
      w_state_nxt = c_idle;
    end else begin
      case (r_state)
        c_idle, c_done: begin
          if (start && w_cfg_ok) begin
            w_state_nxt      = c_run;
            w_addr_nxt       = start_addr;
            w_start_nxt      = start_addr;
            w_end_nxt        = end_addr;
            w_wrap_mode_nxt  = wrap_mode;
            w_burst_mode_nxt = burst_mode;
            w_cnt_nxt        = '0;
          end
        end
        c_run: begin
          if (enable) begin
            // Sequence end without wrap takes precedence over a burst boundary.
            if (w_at_end && !r_wrap_mode) begin
              w_state_nxt = c_done;
            end else begin
              if (w_at_end) begin
                w_addr_nxt = r_start;
                w_wrap_nxt = 1'b1;
              end else begin
                w_addr_nxt = w_addr_inc;
              end
              if (r_burst_mode) begin
                if (w_burst_last) begin
                  w_cnt_nxt        = '0;
                  w_state_nxt      = c_wait;
                  w_burst_done_nxt = 1'b1;
                end else begin
                  w_cnt_nxt = r_cnt + c_cnt_one;
                end
              end
            end
          end
        end
        c_wait: begin
          if (burst_req) begin
            w_state_nxt = c_run;
          end
        end
        default: w_state_nxt = c_idle;
      endcase
    end
  end

  always_comb begin
    addr_valid = (r_state == c_run) && enable;
    ram_addr   = r_addr;
    burst_done = r_burst_done;
    wrap       = r_wrap;
    done       = r_done;
    busy       = r_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_address_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_address_generator
// Brief    : Directed self-checking bench for ram_address_generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_address_generator;

  logic       clk = 1'b0;
  logic       reset, enable, start, abort, wrap_mode, burst_mode, burst_req;
  logic [3:0] start_addr, end_addr, ram_addr;
  logic       addr_valid, burst_done, wrap, done, busy;
  logic [8:0] exp;
  int         checks = 0;
  int         errors = 0;

  ram_address_generator #(
    .ADDRESS_WIDTH  (4),
    .MAX_RAM_ADDRESS(12),
    .BURST_LEN      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .wrap_mode  (wrap_mode),
    .burst_mode (burst_mode),
    .burst_req  (burst_req),
    .ram_addr   (ram_addr),
    .addr_valid (addr_valid),
    .burst_done (burst_done),
    .wrap       (wrap),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [3:0] sa, input logic [3:0] ea, input logic wm, input logic bm);
    start_addr = sa; end_addr = ea; wrap_mode = wm; burst_mode = bm; start = 1'b1;
    step();
    start = 1'b0;
    #1;
  endtask

  // Observed tuple: {ram_addr, addr_valid, burst_done, wrap, done, busy}
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    exp = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL reset got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
  endtask

  task automatic test_linear();
    enable = 1'b1;
    kick(4'd2, 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp = {4'(2 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
        errors++; $display("FAIL linear[%0d] got %b want %b", i, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      exp = {4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
        errors++; $display("FAIL linear_done[%0d] got %b want %b", i, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    kick(4'd3, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      exp = {4'(3 + i % 3), 1'b1, 1'b0, (i >= 3 && i % 3 == 0), 1'b0, 1'b1};
      checks++;
      if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
        errors++; $display("FAIL wrap[%0d] got %b want %b", i, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
      end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    exp = {4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL wrap_abort got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
  endtask

  task automatic test_modulo();
    logic [3:0] seq [4];
    seq = '{4'd10, 4'd11, 4'd0, 4'd1};
    kick(4'd10, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp = {seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
        errors++; $display("FAIL modulo[%0d] got %b want %b", i, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
      end
      step();
    end
    exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL modulo_done got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    kick(4'd12, 4'd3, 1'b0, 1'b0);
    exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL modulo_bad_start got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
    kick(4'd3, 4'd12, 1'b0, 1'b0);
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL modulo_bad_end got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
  endtask

  task automatic test_burst();
    kick(4'd0, 4'd11, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        exp = {4'(4 * b + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
          errors++; $display("FAIL burst[%0d][%0d] got %b want %b", b, i, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
        end
        step();
      end
      if (b < 2) begin
        for (int w = 0; w < 5; w++) begin
          exp = {4'(4 * b + 4), 1'b0, (w == 0), 1'b0, 1'b0, 1'b1};
          checks++;
          if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
            errors++; $display("FAIL burst_wait[%0d][%0d] got %b want %b", b, w, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
          end
          step();
        end
        burst_req = 1'b1;
        step();
        burst_req = 1'b0;
        #1;
      end
    end
    exp = {4'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL burst_end got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
    burst_req = 1'b1;
    step();
    burst_req = 1'b0;
    #1;
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL burst_req_in_done got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
  endtask

  task automatic test_stall_abort();
    kick(4'd0, 4'd11, 1'b0, 1'b0);
    repeat (6) step();
    enable = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp = {4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
        errors++; $display("FAIL stall[%0d] got %b want %b", i, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
      end
      step();
    end
    enable = 1'b1; abort = 1'b1; start = 1'b1; start_addr = 4'd2; end_addr = 4'd9;
    step();
    abort = 1'b0; start = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp = {4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
        errors++; $display("FAIL abort_start[%0d] got %b want %b", i, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
      end
      step();
    end
  endtask

  task automatic test_wrap_burst();
    kick(4'd5, 4'd5, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp = {4'd5, (i < 4), (i == 4), (i > 0), 1'b0, 1'b1};
      checks++;
      if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
        errors++; $display("FAIL wrap_burst[%0d] got %b want %b", i, {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
      end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset_wait();
    kick(4'd0, 4'd11, 1'b0, 1'b1);
    repeat (4) step();
    exp = {4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL reset_wait_pre got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    exp = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL reset_wait got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
    burst_req = 1'b1;
    step();
    burst_req = 1'b0;
    #1;
    checks++;
    if ({ram_addr, addr_valid, burst_done, wrap, done, busy} !== exp) begin
      errors++; $display("FAIL reset_wait_req got %b want %b", {ram_addr, addr_valid, burst_done, wrap, done, busy}, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = '0; end_addr = '0; wrap_mode = 1'b0; burst_mode = 1'b0; burst_req = 1'b0;
    test_reset();
    test_linear();
    test_wrap();
    test_modulo();
    test_burst();
    test_stall_abort();
    test_wrap_burst();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
